// File: rtl/aes_round_sequencer.sv
// Round sequencer for one AES-128 block: steps round_index 0..NR, drives the key-store and
// init/final selects, and holds the result until the consumer takes it.
module aes_round_sequencer #(
   parameter int unsigned NR    = 10,
   parameter int unsigned IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             load_key,
   output logic [IDX_W-1:0] round_index,
   output logic             round_en,
   output logic             key_we,
   output logic             init_round,
   output logic             final_round,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLoad  = 3'd1,
      StInit  = 3'd2,
      StRound = 3'd3,
      StFinal = 3'd4,
      StHold  = 3'd5
   } state_e;

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NR);
   localparam logic [IDX_W-1:0] PreLast = IDX_W'(NR - 1);
   localparam logic [IDX_W-1:0] OneIdx  = IDX_W'(1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         StIdle: begin
            idx_d = '0;
            if (in_valid) state_d = StLoad;
         end
         StLoad: begin
            idx_d   = '0;
            state_d = StInit;
         end
         StInit: begin
            idx_d   = OneIdx;
            state_d = (NR == 1) ? StFinal : StRound;
         end
         StRound: begin
            // Saturate at NR so the counter can never run past the last round.
            if (idx_q >= PreLast) begin
               idx_d   = LastIdx;
               state_d = StFinal;
            end else begin
               idx_d = idx_q + OneIdx;
            end
         end
         StFinal: begin
            idx_d   = LastIdx;
            state_d = StHold;
         end
         StHold: begin
            idx_d = LastIdx;
            if (out_ready) begin
               idx_d   = '0;
               state_d = StIdle;
            end
         end
         default: begin
            idx_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      in_ready    = 1'b0;
      load_key    = 1'b0;
      round_en    = 1'b0;
      init_round  = 1'b0;
      final_round = 1'b0;
      out_valid   = 1'b0;
      case (state_q)
         StIdle:  in_ready = 1'b1;
         StLoad:  load_key = 1'b1;
         StInit: begin
            round_en   = 1'b1;
            init_round = 1'b1;
         end
         StRound: round_en = 1'b1;
         StFinal: begin
            round_en    = 1'b1;
            final_round = 1'b1;
         end
         StHold:  out_valid = 1'b1;
         default: in_ready = 1'b0;
      endcase
      busy        = (state_q != StIdle);
      round_index = idx_q;
      key_we      = round_en && (idx_q != LastIdx);
   end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer (NR=10): per-cycle output vectors checked against
// hand-derived expectations for each scenario.
module tb_aes_round_sequencer;

   localparam int unsigned NR    = 10;
   localparam int unsigned IDX_W = 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic             load_key;
   logic [IDX_W-1:0] round_index;
   logic             round_en;
   logic             key_we;
   logic             init_round;
   logic             final_round;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   int checks;
   int failures;

   aes_round_sequencer #(
      .NR    (NR),
      .IDX_W (IDX_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .load_key    (load_key),
      .round_index (round_index),
      .round_en    (round_en),
      .key_we      (key_we),
      .init_round  (init_round),
      .final_round (final_round),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {in_ready, load_key, round_en, key_we, init_round, final_round, out_valid, busy, index}
   logic [11:0] obs;
   assign obs = {in_ready, load_key, round_en, key_we, init_round, final_round,
                 out_valid, busy, round_index};

   function automatic logic [11:0] mk(input logic ir, input logic lk, input logic re,
                                      input logic kw, input logic ini, input logic fin,
                                      input logic ov, input logic bz, input logic [3:0] idx);
      return {ir, lk, re, kw, ini, fin, ov, bz, idx};
   endfunction

   // Expected outputs k cycles after the accept edge; HOLD lasts hold_len cycles.
   function automatic logic [11:0] exp_at(input int k, input int hold_len);
      if (k <= 0 || k > 12 + hold_len) return mk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0);
      if (k == 1)  return mk(0, 1, 0, 0, 0, 0, 0, 1, 4'd0);
      if (k == 2)  return mk(0, 0, 1, 1, 1, 0, 0, 1, 4'd0);
      if (k <= 11) return mk(0, 0, 1, 1, 0, 0, 0, 1, 4'(k - 2));
      if (k == 12) return mk(0, 0, 1, 0, 0, 1, 0, 1, 4'd10);
      return mk(0, 0, 0, 0, 0, 0, 1, 1, 4'd10);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts from IDLE; pulse_at>0 raises in_valid during that cycle while busy.
   task automatic run_block(input string name, input int hold_len, input int pulse_at);
      logic [11:0] e;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      for (int k = 1; k <= 13 + hold_len; k++) begin
         step();
         e = exp_at(k, hold_len);
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL %s cycle T+%0d: got %03h expected %03h", name, k, obs, e);
         end
         in_valid  = (k == pulse_at);
         out_ready = (k == 12 + hold_len);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0)) begin
            failures++;
            $display("FAIL reset cycle %0d: got %03h expected %03h", i, obs,
                     mk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0));
         end
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      step();
      checks++;
      if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0)) begin
         failures++;
         $display("FAIL reset_release: got %03h expected %03h", obs,
                  mk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0));
      end
   endtask

   task automatic test_single_block();
      run_block("single", 1, 0);
   endtask

   task automatic test_backpressure();
      run_block("backpressure", 6, 0);
   endtask

   task automatic test_busy_ignore();
      run_block("busy_ignore", 1, 5);
      // A queued request would show up here as a second accept.
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0)) begin
            failures++;
            $display("FAIL busy_ignore_idle %0d: got %03h expected idle", i, obs);
         end
      end
   endtask

   task automatic test_reset_mid();
      in_valid  = 1'b1;
      out_ready = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         in_valid = 1'b0;
         checks++;
         if (obs !== exp_at(k, 1)) begin
            failures++;
            $display("FAIL reset_mid_pre T+%0d: got %03h expected %03h", k, obs, exp_at(k, 1));
         end
      end
      rst      = 1'b1;
      in_valid = 1'b1;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0)) begin
         failures++;
         $display("FAIL reset_mid_idle: got %03h expected %03h", obs,
                  mk(1, 0, 0, 0, 0, 0, 0, 0, 4'd0));
      end
      run_block("after_reset", 1, 0);
   endtask

   task automatic test_back_to_back();
      int n_init;
      int n_fin;
      logic [11:0] e;
      n_init    = 0;
      n_fin     = 0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int k = 1; k <= 42; k++) begin
         step();
         if (init_round)  n_init++;
         if (final_round) n_fin++;
         e = exp_at(((k - 1) % 14) + 1, 1);
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL back_to_back T+%0d: got %03h expected %03h", k, obs, e);
         end
         if (k == 42) in_valid = 1'b0;
      end
      out_ready = 1'b0;
      checks++;
      if (n_init !== 3) begin
         failures++;
         $display("FAIL b2b_init_count: got %0d expected 3", n_init);
      end
      checks++;
      if (n_fin !== 3) begin
         failures++;
         $display("FAIL b2b_final_count: got %0d expected 3", n_fin);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_single_block();
      test_backpressure();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
